// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word-addressed SRAM target with optional wait states,
// two-cycle ERROR responses and write-to-read forwarding for back-to-back pipelining.
module ahb_sram_slave #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);
  localparam logic [2:0]  WS   = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            hready_q, hready_d;
  logic            hresp_q, hresp_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic            dp_vld_q, dp_vld_d;
  logic            dp_wr_q, dp_wr_d;
  logic [AW-1:0]   dp_idx_q, dp_idx_d;
  logic [31:0]     mem_q [DEPTH];

  logic [31:0]     off;
  logic [AW-1:0]   samp_idx;
  logic [AW-1:0]   rd_idx;
  logic            addr_ok;
  logic            sample;
  logic            wr_commit;
  logic            rd_load;

  // Address decode relative to the window base (unsigned wrap catches addresses below base)
  assign off       = HADDR - BASE_ADDR;
  assign samp_idx  = off[AW+1:2];
  assign addr_ok   = (off < SPAN) && (HADDR[1:0] == 2'b00);
  assign sample    = hready_q && HTRANS[1];
  // A pending OKAY write completes on any edge where the bus is ready
  assign wr_commit = hready_q && dp_vld_q && dp_wr_q;

  // Next-state, data-phase bookkeeping and read-data load
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dp_vld_d = dp_vld_q;
    dp_wr_d  = dp_wr_q;
    dp_idx_d = dp_idx_q;
    hrdata_d = hrdata_q;
    rd_load  = 1'b0;
    rd_idx   = dp_idx_q;

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        // Any OKAY data phase in flight completes on this edge
        dp_vld_d = 1'b0;
        state_d  = ST_IDLE;
        if (sample) begin
          if (addr_ok) begin
            dp_vld_d = 1'b1;
            dp_wr_d  = HWRITE;
            dp_idx_d = samp_idx;
            if (WS != 3'd0) begin
              state_d = ST_WAIT;
              cnt_d   = WS;
            end else begin
              rd_load = !HWRITE;
              rd_idx  = samp_idx;
            end
          end else begin
            state_d = ST_ERR1;
            if (!HWRITE) hrdata_d = '0;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_IDLE;
          rd_load = !dp_wr_q;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // Forward a write committing on the same edge to the same word
    if (rd_load) begin
      hrdata_d = (wr_commit && (dp_idx_q == rd_idx)) ? HWDATA : mem_q[rd_idx];
    end

    hready_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // Control and output registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
      dp_vld_q <= 1'b0;
      dp_wr_q  <= 1'b0;
      dp_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      hrdata_q <= hrdata_d;
      dp_vld_q <= dp_vld_d;
      dp_wr_q  <= dp_wr_d;
      dp_idx_q <= dp_idx_d;
    end
  end

  // Storage array; cleared on reset, written when an OKAY write data phase completes
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_commit) begin
      mem_q[dp_idx_q] <= HWDATA;
    end
  end

  assign HRDATA = hrdata_q;
  assign HREADY = hready_q;
  assign HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: three slave instances (different wait states / base) driven by a
// cycle-level AHB master, checked against a transfer-level memory model.
module tb_ahb_sram_slave;

  localparam int DEPTH = 16;
  localparam int NI    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       hreset;
  logic [NI-1:0][1:0]  htrans;
  logic [NI-1:0][31:0] haddr;
  logic [NI-1:0]       hwrite;
  logic [NI-1:0][31:0] hwdata;
  logic [NI-1:0][31:0] hrdata;
  logic [NI-1:0]       hready;
  logic [NI-1:0]       hresp;

  ahb_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hreset[0]), .HTRANS(htrans[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]));
  ahb_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) u_dut1 (
    .HCLK(clk), .HRESET(hreset[1]), .HTRANS(htrans[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]));
  ahb_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) u_dut2 (
    .HCLK(clk), .HRESET(hreset[2]), .HTRANS(htrans[2]), .HADDR(haddr[2]), .HWRITE(hwrite[2]),
    .HWDATA(hwdata[2]), .HRDATA(hrdata[2]), .HREADY(hready[2]), .HRESP(hresp[2]));

  typedef struct packed {
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mm [NI][DEPTH];
  op_t         ops [$];

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic bit addr_valid(input int k, input logic [31:0] a);
    logic [31:0] o;
    o = a - base_of(k);
    return (o < 32'(DEPTH * 4)) && (a[1:0] == 2'b00);
  endfunction

  function automatic int word_of(input int k, input logic [31:0] a);
    logic [31:0] o;
    o = a - base_of(k);
    return int'(o >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                      input logic [31:0] d);
    op_t o;
    o.tr = tr; o.wr = wr; o.addr = a; o.data = d;
    ops.push_back(o);
  endtask

  // Drive the queued ops on instance k cycle by cycle; called and returns at a negedge
  task automatic run_ops(input int k);
    op_t dp, cur;
    bit  in_dp = 1'b0;
    bit  err = 1'b0;
    bit  rdy;
    int  cyc = 0;
    int  len = 0;
    int  budget = 0;
    while ((ops.size() > 0 || in_dp) && budget < 4000) begin
      budget++;
      if (in_dp) begin
        cyc++;
        hwdata[k] = dp.data;
        check("hready_dp", 32'(hready[k]), 32'(cyc == len));
        check("hresp_dp", 32'(hresp[k]), 32'(err));
        if (cyc == len) begin
          if (!dp.wr) check("hrdata", hrdata[k], err ? 32'h0 : mm[k][word_of(k, dp.addr)]);
          else if (!err) mm[k][word_of(k, dp.addr)] = dp.data;
        end
      end else begin
        hwdata[k] = $urandom;
        check("hready_nodp", 32'(hready[k]), 32'h1);
        check("hresp_nodp", 32'(hresp[k]), 32'h0);
      end
      rdy = !in_dp || (cyc == len);
      if (rdy) begin
        if (ops.size() > 0) cur = ops.pop_front();
        else begin
          cur.tr = 2'b00; cur.wr = 1'b0; cur.addr = 32'h0; cur.data = 32'h0;
        end
        htrans[k] = cur.tr;
        haddr[k]  = cur.addr;
        hwrite[k] = cur.wr;
      end else begin
        // Address-phase noise while stalled must be ignored
        htrans[k] = 2'b10;
        haddr[k]  = base_of(k) + 32'($urandom_range(0, DEPTH - 1) * 4);
        hwrite[k] = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      if (rdy) begin
        in_dp = cur.tr[1];
        dp    = cur;
        cyc   = 0;
        err   = !addr_valid(k, cur.addr);
        len   = err ? 2 : ws_of(k) + 1;
      end
      @(negedge clk);
    end
    check("run_timeout", 32'(budget < 4000), 32'h1);
    htrans[k] = 2'b00;
    hwrite[k] = 1'b0;
  endtask

  task automatic push_random(input int k, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0:       a = base_of(k) + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
        1:       a = base_of(k) + 32'(DEPTH * 4) + 32'($urandom_range(0, 3) * 4);
        2:       a = base_of(k) - 32'($urandom_range(1, 4) * 4);
        default: a = base_of(k) + 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      push(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  task automatic push_readback(input int k);
    for (int w = 0; w < DEPTH; w++) push(2'b10, 1'b0, base_of(k) + 32'(w * 4), 32'h0);
  endtask

  task automatic clear_model(input int k);
    for (int w = 0; w < DEPTH; w++) mm[k][w] = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      hreset[k] = 1'b1; htrans[k] = 2'b00; haddr[k] = 32'h0; hwrite[k] = 1'b0; hwdata[k] = 32'h0;
      clear_model(k);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    hreset = '0;
    for (int k = 0; k < NI; k++) begin
      check("rst_hready", 32'(hready[k]), 32'h1);
      check("rst_hresp", 32'(hresp[k]), 32'h0);
      check("rst_hrdata", hrdata[k], 32'h0);
    end

    // Zero-wait instance: basic write/read, back-to-back forwarding, errors, readback
    push(2'b10, 1'b1, 32'h4, 32'h89AB_CDEF);
    push(2'b00, 1'b0, 32'h0, 32'h0);
    push(2'b10, 1'b0, 32'h4, 32'h0);
    push(2'b10, 1'b1, 32'h8, 32'h0000_F00F);
    push(2'b10, 1'b0, 32'h8, 32'h0);
    push(2'b10, 1'b1, 32'h40, 32'hDEAD_BEEF);
    push(2'b10, 1'b1, 32'h2, 32'hDEAD_BEEF);
    push(2'b11, 1'b0, 32'h40, 32'h0);
    push(2'b01, 1'b1, 32'h0, 32'h1111_1111);
    push(2'b00, 1'b1, 32'h3C, 32'h2222_2222);
    push(2'b11, 1'b1, 32'h3C, 32'h3C3C_3C3C);
    push(2'b11, 1'b0, 32'h3C, 32'h0);
    push_readback(0);
    run_ops(0);
    push_random(0, 200);
    push_readback(0);
    run_ops(0);

    // Three-wait instance: first read after reset, errors, random traffic
    push(2'b10, 1'b0, 32'h0, 32'h0);
    push(2'b10, 1'b1, 32'h40, 32'hDEAD_BEEF);
    push(2'b10, 1'b1, 32'h2, 32'hDEAD_BEEF);
    push_readback(1);
    run_ops(1);
    push_random(1, 150);
    push_readback(1);
    run_ops(1);

    // Two-wait instance at a non-zero base: traffic, then reset during a write wait
    push(2'b10, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF);
    push(2'b10, 1'b1, 32'h0000_103C, 32'hCAFE_F00D);
    push(2'b10, 1'b1, 32'h0000_1040, 32'hDEAD_BEEF);
    push(2'b10, 1'b0, 32'h0000_103C, 32'h0);
    run_ops(2);
    push_random(2, 150);
    run_ops(2);
    htrans[2] = 2'b10; haddr[2] = 32'h0000_100C; hwrite[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    htrans[2] = 2'b00; hwdata[2] = 32'h1234_5678;
    check("rst_mid_wait", 32'(hready[2]), 32'h0);
    hreset[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hreset[2] = 1'b0;
    clear_model(2);
    check("rst_mid_hready", 32'(hready[2]), 32'h1);
    check("rst_mid_hresp", 32'(hresp[2]), 32'h0);
    push(2'b10, 1'b0, 32'h0000_100C, 32'h0);
    push_readback(2);
    run_ops(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
